rsa_controller: RTL and testbench
=================================

RSA_CONTROLLER -- requirements
Module: rsa_controller

Interface
REQ-001 Parameter: E_VALUE, default 17, public exponent; SHALL equal the datapath exponent.
REQ-002 Parameter: TIMEOUT_CYCLES, default 128, watchdog limit in cycles.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port in_data, input, 8, plaintext byte.
REQ-007 Port in_valid, input, 1, in_data valid.
REQ-008 Port in_ready, output, 1, block accepts a byte.
REQ-009 Port dp_data, output, 8, registered byte to datapath data.
REQ-010 Port dp_initialize / dp_en_multiply / dp_en_modulo / dp_done, output, 1 each, datapath controls.
REQ-011 Port dp_is_init_done / dp_is_mult_done, input, 1 each, datapath status flags.
REQ-012 Port dp_output_data, input, 16, datapath result.
REQ-013 Port out_data, output, 16, ciphertext.
REQ-014 Port out_valid, output, 1, out_data valid.
REQ-015 Port out_ready, input, 1, consumer accepts.
REQ-016 Port busy, output, 1, high in any state except IDLE.
REQ-017 Port err_timeout, output, 1, sticky watchdog error.

Function
REQ-018 FSM states: IDLE, INIT, WAIT_INIT, MUL, MOD, CHECK, DONE, CAPTURE, OUT.
REQ-019 IDLE: in_ready=1; on in_valid&&in_ready, latch in_data into dp_data; go to INIT.
REQ-020 INIT: dp_initialize=1 for exactly one cycle; go to WAIT_INIT.
REQ-021 WAIT_INIT: ignore dp_is_init_done in the first cycle (stale flag); afterwards go to MUL when it is 1.
REQ-022 MUL: dp_en_multiply=1 for one cycle, then MOD.
REQ-023 MOD: dp_en_modulo=1 for one cycle, then CHECK.
REQ-024 CHECK: no enables; if dp_is_mult_done=1 go to DONE, else go to MUL.
REQ-025 DONE: dp_done=1 for one cycle, then CAPTURE.
REQ-026 CAPTURE: latch dp_output_data into out_data; set out_valid; go to OUT.
REQ-027 OUT: hold out_data and out_valid stable until out_valid&&out_ready; then clear out_valid and go to IDLE.
REQ-028 At most one dp_* control SHALL be high in any cycle; all dp_* controls are registered outputs.
REQ-029 in_valid is ignored outside IDLE; out_ready is ignored while out_valid=0.
REQ-030 Latency for E_VALUE=17: out_valid rises 53 edges after the accepting edge (E_VALUE-1 = 16 MUL/MOD/CHECK loops).
REQ-031 Throughput: a new byte is accepted no earlier than the cycle after the output handshake.

Reset
REQ-032 While rst_n=0, asynchronously force: state=IDLE, dp_data=0, all dp_* controls=0, out_data=0, out_valid=0, busy=0, err_timeout=0.
REQ-033 in_ready=1 from the first cycle after rst_n deasserts.
REQ-034 Reset mid-operation aborts the operation with no output. The datapath has no reset; the next operation re-initialises it through INIT.

Configuration
REQ-035 Macro: RSA_CTRL_WATCHDOG_EN.
REQ-036 Defined: a counter clears on INIT and increments in WAIT_INIT, MUL, MOD and CHECK.
REQ-037 Defined: when the counter reaches TIMEOUT_CYCLES, set err_timeout (sticky until reset), return to IDLE, and produce no output.
REQ-038 Undefined: no counter; err_timeout is tied to 0.

Structure
REQ-039 Package rsa_pkg SHALL hold: the state enum, E_VALUE default, and width constants (DATA_W=8, RESULT_W=16).
REQ-040 One sub-module, rsa_watchdog (counter plus compare), instantiated only under RSA_CTRL_WATCHDOG_EN.
REQ-041 The controller connects to the existing datapath port-for-port; the datapath needs no changes.

Verification
REQ-042 Nominal: in_data=65 with the real datapath (n=3233, e=17) -> out_data=2790, out_valid at edge 53.
REQ-043 Edge values: in_data=0 -> out_data=0; in_data=1 -> out_data=1; in_data=255 -> out_data=(255^17 mod 3233) from a reference model.
REQ-044 Backpressure: out_ready=0 for 10 cycles after out_valid -> out_data held at 2790, in_ready=0; release -> IDLE next cycle.
REQ-045 Reset mid-op: assert rst_n=0 at cycle 20 of an in_data=65 run -> all outputs 0 immediately; rerun in_data=65 -> 2790.
REQ-046 Watchdog (macro defined): hold dp_is_mult_done=0 -> err_timeout=1 at TIMEOUT_CYCLES, out_valid never asserts. Macro undefined: err_timeout stays 0.
REQ-047 Protocol checks: one-hot-or-zero dp_* controls, and in_valid while busy never accepted.

Source files
------------

// File: rtl/rsa_pkg.sv
// -----------------------------------------------------------------------------
// rsa_pkg
// Shared definitions for the RSA encryption controller:
//   - controller state encoding (state_t)
//   - default public exponent and watchdog limit
//   - datapath width constants (DATA_W plaintext byte, RESULT_W ciphertext)
//   - is_active(): states in which the datapath is being driven through an
//     exponentiation and the watchdog is allowed to run
// -----------------------------------------------------------------------------
package rsa_pkg;

    localparam int DATA_W          = 8;
    localparam int RESULT_W        = 16;
    localparam int E_VALUE_DEFAULT = 17;
    localparam int TIMEOUT_DEFAULT = 128;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_INIT      = 4'd1,
        S_WAIT_INIT = 4'd2,
        S_MUL       = 4'd3,
        S_MOD       = 4'd4,
        S_CHECK     = 4'd5,
        S_DONE      = 4'd6,
        S_CAPTURE   = 4'd7,
        S_OUT       = 4'd8
    } state_t;

    // States where the controller waits on or steps the datapath.
    function automatic logic is_active(input state_t s);
        return (s == S_WAIT_INIT) || (s == S_MUL) ||
               (s == S_MOD)       || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/rsa_watchdog.sv
// -----------------------------------------------------------------------------
// rsa_watchdog
// Cycle counter plus compare used to abort a stuck exponentiation.
// Only instantiated when RSA_CTRL_WATCHDOG_EN is defined.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   i_clear    restart the count from zero (controller in INIT)
//   i_count_en advance the count by one (controller in an active state)
//   o_expired  count has reached TIMEOUT_CYCLES
// -----------------------------------------------------------------------------
module rsa_watchdog
    import rsa_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;
    logic             w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign o_expired  = w_at_limit;

    // Saturates at the limit so a controller that ignores the expiry can
    // never see the count wrap back below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rsa_controller.sv
// -----------------------------------------------------------------------------
// rsa_controller
// Sequences an external modular-exponentiation datapath to encrypt one
// plaintext byte per operation (c = m^E mod n). The datapath performs one
// multiply and one modulo per loop and raises dp_is_mult_done after E-1
// loops; the controller only steps it and handshakes the byte in and the
// 16-bit result out.
//
// Optional feature: define RSA_CTRL_WATCHDOG_EN to add a cycle watchdog that
// aborts a stalled operation, returns to IDLE without output and raises the
// sticky err_timeout flag. Without the macro err_timeout is constant 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  plaintext byte input handshake
//   dp_data                    byte latched for the datapath
//   dp_initialize              one-cycle datapath init pulse
//   dp_en_multiply             one-cycle multiply enable
//   dp_en_modulo               one-cycle modulo enable
//   dp_done                    one-cycle end-of-operation pulse
//   dp_is_init_done            datapath status: initialisation complete
//   dp_is_mult_done            datapath status: all loops complete
//   dp_output_data             datapath result
//   out_data/out_valid/out_ready  ciphertext output handshake
//   busy                       controller is not in IDLE
//   err_timeout                sticky watchdog error
// -----------------------------------------------------------------------------
module rsa_controller
    import rsa_pkg::*;
#(
    parameter int E_VALUE        = E_VALUE_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   dp_data,
    output logic                dp_initialize,
    output logic                dp_en_multiply,
    output logic                dp_en_modulo,
    output logic                dp_done,
    input  logic                dp_is_init_done,
    input  logic                dp_is_mult_done,
    input  logic [RESULT_W-1:0] dp_output_data,
    output logic [RESULT_W-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                err_timeout
);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_wait_armed;
    logic                w_accept;
    logic                w_timeout;

    logic [DATA_W-1:0]   r_dp_data;
    logic                r_dp_initialize;
    logic                r_dp_en_multiply;
    logic                r_dp_en_modulo;
    logic                r_dp_done;
    logic [RESULT_W-1:0] r_out_data;
    logic                r_out_valid;

    // in_ready is gated by rst_n so every output reads 0 while reset is held.
    assign in_ready = rst_n && (r_state == S_IDLE);
    assign busy     = (r_state != S_IDLE);
    assign w_accept = in_valid && (r_state == S_IDLE);

`ifdef RSA_CTRL_WATCHDOG_EN
    logic w_wd_clear;
    logic w_wd_count;
    logic r_err_timeout;

    assign w_wd_clear = (r_state == S_INIT);
    assign w_wd_count = is_active(r_state);

    rsa_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_wd_clear),
        .i_count_en (w_wd_count),
        .o_expired  (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_timeout <= 1'b0;
        end else if (w_timeout && is_active(r_state)) begin
            r_err_timeout <= 1'b1;
        end
    end

    assign err_timeout = r_err_timeout;
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_armed <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            // Low during the first WAIT_INIT cycle, when dp_is_init_done may
            // still carry the previous operation's value.
            r_wait_armed <= (r_state == S_WAIT_INIT);
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:      if (in_valid) w_state_next = S_INIT;
            S_INIT:      w_state_next = S_WAIT_INIT;
            S_WAIT_INIT: if (r_wait_armed && dp_is_init_done) w_state_next = S_MUL;
            S_MUL:       w_state_next = S_MOD;
            S_MOD:       w_state_next = S_CHECK;
            S_CHECK:     w_state_next = dp_is_mult_done ? S_DONE : S_MUL;
            S_DONE:      w_state_next = S_CAPTURE;
            S_CAPTURE:   w_state_next = S_OUT;
            S_OUT:       if (r_out_valid && out_ready) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
        // A watchdog expiry overrides any progress and drops the operation.
        if (w_timeout && is_active(r_state)) begin
            w_state_next = S_IDLE;
        end
    end

    // Registered outputs. Datapath controls are decoded from the next state,
    // so each pulse lines up with its state and at most one can be high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_data        <= '0;
            r_dp_initialize  <= 1'b0;
            r_dp_en_multiply <= 1'b0;
            r_dp_en_modulo   <= 1'b0;
            r_dp_done        <= 1'b0;
            r_out_data       <= '0;
            r_out_valid      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_dp_data <= in_data;
            end
            r_dp_initialize  <= (w_state_next == S_INIT);
            r_dp_en_multiply <= (w_state_next == S_MUL);
            r_dp_en_modulo   <= (w_state_next == S_MOD);
            r_dp_done        <= (w_state_next == S_DONE);
            if (r_state == S_CAPTURE) begin
                r_out_data  <= dp_output_data;
                r_out_valid <= 1'b1;
            end else if (r_state == S_OUT && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign dp_data        = r_dp_data;
    assign dp_initialize  = r_dp_initialize;
    assign dp_en_multiply = r_dp_en_multiply;
    assign dp_en_modulo   = r_dp_en_modulo;
    assign dp_done        = r_dp_done;
    assign out_data       = r_out_data;
    assign out_valid      = r_out_valid;

endmodule

// File: tb/tb_rsa_controller.sv
// -----------------------------------------------------------------------------
// tb_rsa_controller
// Drives rsa_controller against a behavioural model of the RSA datapath
// (n = 3233, e = 17) and compares results with a plain modular-exponentiation
// reference. Watchdog expectations follow RSA_CTRL_WATCHDOG_EN.
// -----------------------------------------------------------------------------
module tb_rsa_controller;

    localparam int N_MOD   = 3233;
    localparam int E       = 17;
    localparam int TMO     = 128;
    localparam int LATENCY = 53;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic [7:0]  dp_data;
    logic        dp_initialize, dp_en_multiply, dp_en_modulo, dp_done;
    logic        dp_is_init_done, dp_is_mult_done;
    logic [15:0] dp_output_data;
    logic [15:0] out_data;
    logic        out_valid, busy, err_timeout;

    int vectors = 0;
    int miscompares = 0;
    bit stall_mult = 1'b0;

    always #5 clk = ~clk;

    rsa_controller #(
        .E_VALUE        (E),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dp_data         (dp_data),
        .dp_initialize   (dp_initialize),
        .dp_en_multiply  (dp_en_multiply),
        .dp_en_modulo    (dp_en_modulo),
        .dp_done         (dp_done),
        .dp_is_init_done (dp_is_init_done),
        .dp_is_mult_done (dp_is_mult_done),
        .dp_output_data  (dp_output_data),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .busy            (busy),
        .err_timeout     (err_timeout)
    );

    // Datapath model: acc = m on init, then acc = acc*m mod n once per
    // multiply/modulo pair; done after E-1 pairs. No reset, like the real one.
    int dp_acc = 0;
    int dp_prod = 0;
    int dp_cnt = 0;
    bit dp_init_flag = 1'b0;

    always @(posedge clk) begin
        if (dp_initialize) begin
            dp_acc       <= int'(dp_data);
            dp_cnt       <= 0;
            dp_init_flag <= 1'b1;
        end
        if (dp_en_multiply) dp_prod <= dp_acc * int'(dp_data);
        if (dp_en_modulo) begin
            dp_acc <= dp_prod % N_MOD;
            dp_cnt <= dp_cnt + 1;
        end
    end

    assign dp_is_init_done = dp_init_flag;
    assign dp_is_mult_done = (dp_cnt == E - 1) && !stall_mult;
    assign dp_output_data  = 16'(dp_acc);

    function automatic int rsa_ref(input int m);
        int r = 1;
        for (int i = 0; i < E; i++) r = (r * m) % N_MOD;
        return r;
    endfunction

    // Continuous protocol checks.
    always @(negedge clk) begin
        if (rst_n) begin
            vectors++;
            if ($countones({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done}) > 1) begin
                miscompares++;
                $display("FAIL dp_onehot: got %b required at most one high",
                         {dp_initialize, dp_en_multiply, dp_en_modulo, dp_done});
            end
            vectors++;
            if (in_ready !== !busy) begin
                miscompares++;
                $display("FAIL ready_busy: in_ready=%b busy=%b required complementary", in_ready, busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation from IDLE back to IDLE. spam keeps in_valid high with
    // random bytes and toggles out_ready randomly before out_valid rises.
    task automatic run_op(input logic [7:0] d, input int stall, input bit spam,
                          input logic [15:0] exp_val, input string tag);
        int n = 0;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_ready: in_ready=%b required 1", tag, in_ready);
        end
        in_data  = d;
        in_valid = 1'b1;
        tick();
        vectors++;
        if (dp_data !== d) begin
            miscompares++;
            $display("FAIL %s_dp_data: got %0d required %0d", tag, dp_data, d);
        end
        in_valid = spam;
        while (out_valid !== 1'b1 && n < 300) begin
            if (spam) begin
                in_data   = 8'($urandom);
                out_ready = 1'($urandom);
            end
            tick();
            n++;
            vectors++;
            if (dp_data !== d) begin
                miscompares++;
                $display("FAIL %s_dp_hold: got %0d required %0d at cycle %0d", tag, dp_data, d, n);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (n != LATENCY) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d required %0d", tag, n, LATENCY);
        end
        if (n >= 300) return;
        vectors++;
        if (out_data !== exp_val) begin
            miscompares++;
            $display("FAIL %s_out_data: got %0d required %0d", tag, out_data, exp_val);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exp_val || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_hold: valid=%b data=%0d ready=%b required 1/%0d/0",
                         tag, out_valid, out_data, in_ready, exp_val);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_release: valid=%b ready=%b busy=%b required 0/1/0",
                     tag, out_valid, in_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if ({dp_data, dp_initialize, dp_en_multiply, dp_en_modulo, dp_done,
             out_data, out_valid, busy, err_timeout, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: out=%0d valid=%b busy=%b ready=%b required all 0",
                     out_data, out_valid, busy, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || err_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b err=%b required 1/0/0",
                     in_ready, busy, err_timeout);
        end
    endtask

    task automatic test_nominal();
        run_op(8'd65, 0, 1'b0, 16'd2790, "nominal");
    endtask

    task automatic test_edges();
        run_op(8'd0,   0, 1'b0, 16'(rsa_ref(0)),   "edge0");
        run_op(8'd1,   0, 1'b0, 16'(rsa_ref(1)),   "edge1");
        run_op(8'd255, 0, 1'b0, 16'(rsa_ref(255)), "edge255");
    endtask

    task automatic test_backpressure();
        run_op(8'd65, 10, 1'b0, 16'd2790, "backpressure");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] m;
            m = 8'($urandom);
            run_op(m, int'($urandom_range(0, 3)), 1'b1, 16'(rsa_ref(int'(m))), "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] m;
            m = 8'($urandom_range(2, 255));
            run_op(m, 0, 1'b1, 16'(rsa_ref(int'(m))), "b2b");
        end
    endtask

    task automatic test_reset_midop();
        in_data  = 8'd65;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({dp_data, dp_initialize, dp_en_multiply, dp_en_modulo, dp_done,
             out_data, out_valid, busy, err_timeout, in_ready} !== '0) begin
            miscompares++;
            $display("FAIL midop_reset: out=%0d valid=%b busy=%b data=%0d required all 0",
                     out_data, out_valid, busy, dp_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_op(8'd65, 0, 1'b0, 16'd2790, "rerun");
    endtask

    task automatic test_watchdog();
        int n = 0;
        bit seen_valid = 1'b0;
        stall_mult = 1'b1;
        in_data    = 8'($urandom);
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
`ifdef RSA_CTRL_WATCHDOG_EN
        while (err_timeout !== 1'b1 && n < TMO + 50) begin
            tick();
            n++;
            if (out_valid === 1'b1) seen_valid = 1'b1;
        end
        vectors++;
        if (err_timeout !== 1'b1 || n < TMO || n > TMO + 4) begin
            miscompares++;
            $display("FAIL wd_expire: err=%b after %0d cycles required 1 within [%0d,%0d]",
                     err_timeout, n, TMO, TMO + 4);
        end
        vectors++;
        if (seen_valid || busy !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_abort: seen_valid=%b busy=%b ready=%b required 0/0/1",
                     seen_valid, busy, in_ready);
        end
        stall_mult = 1'b0;
        run_op(8'd65, 0, 1'b0, 16'd2790, "wd_recover");
        vectors++;
        if (err_timeout !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_sticky: err=%b required 1", err_timeout);
        end
`else
        repeat (TMO + 50) begin
            tick();
            if (out_valid === 1'b1) seen_valid = 1'b1;
            vectors++;
            if (err_timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL wd_disabled: err=%b required 0", err_timeout);
            end
        end
        vectors++;
        if (seen_valid || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_stalled: seen_valid=%b busy=%b required 0/1", seen_valid, busy);
        end
        stall_mult = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        vectors++;
        if (err_timeout !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_reset: err=%b ready=%b required 0/1", err_timeout, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_edges();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_midop();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
